// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer controller: register map, CTRL layout, FSM states.
package timer_ctrl_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tstate_t;

  // Packed so that en lands on bit CTRL_EN, periodic on CTRL_PERIODIC, irq_en on CTRL_IRQ_EN.
  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..prescale while running and pulses tick on the terminal value.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] phase;

  assign tick = run & (phase == prescale);

  // Phase counter: held at zero while stopped or cleared, wraps after each tick.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clear || !run || tick) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable timer: bus register file, 32-bit tick counter with compare,
// one-shot/periodic FSM and a latched, write-1-to-clear interrupt.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_COMPARE = 32'd100000,
  parameter int          PRESCALE_W    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        irq
);

  tstate_t               state;
  ctrl_t                 ctrl;
  ctrl_t                 ctrl_next;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           compare;
  logic [31:0]           count;
  logic                  pending;
  logic                  pending_next;
  logic [31:0]           read_data;

  logic wr;
  logic ctrl_wr;
  logic prescale_wr;
  logic compare_wr;
  logic count_wr;
  logic status_w1c;
  logic tick;
  logic expiry;

  assign wr          = bus_sel & bus_we;
  assign ctrl_wr     = wr && (bus_addr == REG_CTRL);
  assign prescale_wr = wr && (bus_addr == REG_PRESCALE);
  assign compare_wr  = wr && (bus_addr == REG_COMPARE);
  assign count_wr    = wr && (bus_addr == REG_COUNT);
  assign status_w1c  = wr && (bus_addr == REG_STATUS) && bus_wdata[0];

  // A COUNT write in the tick cycle wins: the tick is swallowed and cannot expire.
  assign expiry = tick & ~count_wr & (count == compare);

  // Expiry sets PENDING even when a W1C lands in the same cycle.
  assign pending_next = expiry | (pending & ~status_w1c);

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run      (state == RUN),
    .clear    (count_wr),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next CTRL value: a bus write beats the one-shot hardware clear of EN.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    ctrl_next = ctrl;
    if (ctrl_wr) begin
      ctrl_next = ctrl_t'(bus_wdata[2:0]);
    end else if (expiry && !ctrl.periodic) begin
      ctrl_next.en = 1'b0;
    end
  end

  // Read multiplexer; unmapped words and unused bits return zero.
  always_comb begin
    read_data = '0;
    case (bus_addr)
      REG_CTRL:     read_data = 32'(ctrl);
      REG_PRESCALE: read_data = 32'(prescale);
      REG_COMPARE:  read_data = compare;
      REG_COUNT:    read_data = count;
      REG_STATUS:   read_data = 32'(pending);
      default:      read_data = '0;
    endcase
  end

  // Configuration registers written from the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= RESET_COMPARE;
    end else begin
      ctrl <= ctrl_next;
      if (prescale_wr) prescale <= bus_wdata[PRESCALE_W-1:0];
      if (compare_wr)  compare  <= bus_wdata;
    end
  end

  // Run/idle FSM following the effective EN, so a stop or one-shot expiry takes effect at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (ctrl_next.en)  state <= RUN;
        RUN:     if (!ctrl_next.en) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tick counter with compare match; wraps modulo 2^32 when COMPARE is below COUNT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count_wr) begin
      count <= '0;
    end else if (tick) begin
      count <= expiry ? '0 : count + 32'd1;
    end
  end

  // Latched PENDING flag and the registered interrupt that follows it one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      irq     <= 1'b0;
    end else begin
      pending <= pending_next;
      irq     <= pending & ctrl.irq_en;
    end
  end

  // Bus response: one-cycle ready after each access, read data registered, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_ready <= 1'b0;
      bus_rdata <= '0;
    end else begin
      bus_ready <= bus_sel;
      bus_rdata <= (bus_sel && !bus_we) ? read_data : '0;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios with literal timing
// expectations plus randomized bus traffic, all compared every cycle to a model.
module tb_timer_ctrl;
  import timer_ctrl_pkg::*;

  localparam int          PW      = 16;
  localparam int unsigned PS_MASK = (1 << PW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        irq;

  timer_ctrl #(
    .RESET_COMPARE (32'd100000),
    .PRESCALE_W    (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the timer is simply "running" whenever EN is set.
  bit          model_on = 1'b0;
  bit          m_en, m_per, m_ien, m_pend, m_irq, m_ready;
  int unsigned m_phase, m_ps;
  logic [31:0] m_cmp, m_cnt, m_rdata;

  task automatic model_reset();
    {m_en, m_per, m_ien} = 3'b000;
    m_pend  = 1'b0;
    m_irq   = 1'b0;
    m_ready = 1'b0;
    m_rdata = '0;
    m_phase = 0;
    m_ps    = 0;
    m_cmp   = 32'd100000;
    m_cnt   = '0;
  endtask

  function automatic logic [31:0] model_reg(input logic [2:0] addr);
    case (addr)
      3'd0:    return {29'd0, m_ien, m_per, m_en};
      3'd1:    return 32'(m_ps);
      3'd2:    return m_cmp;
      3'd3:    return m_cnt;
      3'd4:    return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across one clock edge given the bus request presented in that cycle.
  task automatic model_step(input bit sel, input bit we, input logic [2:0] addr, input logic [31:0] wd);
    bit          wr       = sel && we;
    bit          running  = m_en;
    bit          tick     = running && (m_phase == m_ps);
    bit          cnt_wr   = wr && (addr == 3'd3);
    bit          expire   = tick && !cnt_wr && (m_cnt == m_cmp);
    bit          old_pend = m_pend;
    bit          old_per  = m_per;
    logic [31:0] rv       = model_reg(addr);
    m_ready = sel;
    m_rdata = (sel && !we) ? rv : 32'd0;
    m_irq   = old_pend && m_ien;
    if (cnt_wr || expire) m_cnt = 32'd0;
    else if (tick)        m_cnt = m_cnt + 32'd1;
    m_phase = (cnt_wr || !running || tick) ? 0 : ((m_phase + 1) & PS_MASK);
    m_pend  = expire || (old_pend && !(wr && addr == 3'd4 && wd[0]));
    if (wr && addr == 3'd0)       {m_ien, m_per, m_en} = wd[2:0];
    else if (expire && !old_per)  m_en = 1'b0;
    if (wr && addr == 3'd1) m_ps  = wd & PS_MASK;
    if (wr && addr == 3'd2) m_cmp = wd;
  endtask

  // Single compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("irq", 32'(irq), 32'(m_irq));
      check("bus_ready", 32'(bus_ready), 32'(m_ready));
      check("bus_rdata", bus_rdata, m_rdata);
    end
  end

  // One bus cycle: drive at the falling edge, step the model at the rising edge.
  task automatic do_cycle(input bit sel, input bit we, input logic [2:0] addr, input logic [31:0] wd);
    bus_sel   = sel;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wd;
    @(posedge clk);
    model_step(sel, we, addr, wd);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] wd);
    do_cycle(1'b1, 1'b1, addr, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
    do_cycle(1'b1, 1'b0, addr, 32'd0);
    check(name, bus_rdata, exp);
    check({name, "_ready"}, 32'(bus_ready), 32'd1);
  endtask

  // Idle until irq is seen high; returns the number of cycles, or -1 if the budget runs out.
  task automatic wait_irq_rise(input int max_cycles, output int k);
    bit seen = 1'b0;
    k = -1;
    for (int i = 1; i <= max_cycles && !seen; i++) begin
      idle(1);
      if (irq === 1'b1) begin
        k    = i;
        seen = 1'b1;
      end
    end
  endtask

  int          k;
  int          r;
  logic [2:0]  ra;
  bit          rwe;
  logic [31:0] rd_data;

  initial begin
    rst       = 1'b1;
    bus_sel   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    model_reset();
    model_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values of every register word.
    rd(3'd0, 32'd0, "rst_ctrl");
    rd(3'd1, 32'd0, "rst_prescale");
    rd(3'd2, 32'd100000, "rst_compare");
    rd(3'd3, 32'd0, "rst_count");
    rd(3'd4, 32'd0, "rst_status");
    for (int a = 5; a < 8; a++) rd(3'(a), 32'd0, "rst_unused");
    check("rst_irq", 32'(irq), 32'd0);

    // Periodic run: P=1, C=3 -> PENDING 8 cycles after RUN entry, irq one cycle later.
    wr(3'd1, 32'd1);
    wr(3'd2, 32'd3);
    wr(3'd0, 32'd7);
    wait_irq_rise(40, k);
    check("periodic_first_irq", 32'(k), 32'd9);
    for (int n = 0; n < 2; n++) begin
      wr(3'd4, 32'd1);
      idle(1);
      check("w1c_irq_drop", 32'(irq), 32'd0);
      wait_irq_rise(40, k);
      check("periodic_period", 32'(k + 2), 32'd8);
    end

    // One-shot: P=0, C=5 -> expiry 6 cycles after entry, EN cleared, no further expiry.
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd5);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd5);
    wait_irq_rise(40, k);
    check("oneshot_irq", 32'(k), 32'd7);
    rd(3'd0, 32'd4, "oneshot_ctrl");
    rd(3'd3, 32'd0, "oneshot_count");
    wr(3'd4, 32'd1);
    idle(50);
    check("oneshot_no_reexpiry", 32'(irq), 32'd0);
    rd(3'd4, 32'd0, "oneshot_status");

    // Collision: W1C lands on the second expiry edge; PENDING and irq stay high.
    wr(3'd1, 32'd1);
    wr(3'd2, 32'd3);
    wr(3'd0, 32'd7);
    idle(15);
    check("collide_irq_before", 32'(irq), 32'd1);
    wr(3'd4, 32'd1);
    check("collide_irq_edge", 32'(irq), 32'd1);
    idle(1);
    check("collide_irq_after", 32'(irq), 32'd1);
    rd(3'd4, 32'd1, "collide_status");

    // Randomized traffic against the model.
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 65) begin
        idle(1);
      end else begin
        ra      = 3'($urandom_range(0, 7));
        rwe     = 1'($urandom_range(0, 1));
        rd_data = $urandom;
        case (ra)
          3'd0: begin
            rd_data = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) rd_data[0] = 1'b1;
          end
          3'd1: begin
            rd_data = 32'($urandom_range(0, 3));
            if (m_en) rwe = 1'b0;
          end
          3'd2: rd_data = m_cnt + 32'($urandom_range(0, 20));
          3'd4: rd_data = 32'($urandom_range(0, 1));
          default: ;
        endcase
        do_cycle(1'b1, rwe, ra, rd_data);
      end
    end

    // COMPARE lowered below COUNT: no expiry while COUNT climbs.
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);
    idle(1);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd100);
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd7);
    idle(9);
    wr(3'd2, 32'd4);
    idle(20);
    check("lowered_no_irq", 32'(irq), 32'd0);
    rd(3'd3, 32'd30, "lowered_count");
    wr(3'd0, 32'd0);

    // Wrap: COUNT placed just below 2^32 runs through 0 and then matches COMPARE=4.
    force dut.count = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    idle(1);
    release dut.count;
    wr(3'd0, 32'd7);
    rd(3'd3, 32'hFFFF_FFFE, "wrap_count0");
    rd(3'd3, 32'hFFFF_FFFF, "wrap_count1");
    rd(3'd3, 32'd0, "wrap_count2");
    wait_irq_rise(40, k);
    check("wrap_irq", 32'(k), 32'd5);

    // Reset mid-run with irq high and a read response in flight.
    rd(3'd3, 32'd1, "pre_reset_count");
    check("pre_reset_irq", 32'(irq), 32'd1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_ready", 32'(bus_ready), 32'd0);
    check("reset_rdata", bus_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(3'd0, 32'd0, "post_reset_ctrl");
    rd(3'd3, 32'd0, "post_reset_count");
    rd(3'd2, 32'd100000, "post_reset_compare");
    rd(3'd4, 32'd0, "post_reset_status");

    model_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
